fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the instruction ROM.
- Generates the word address for the ROM and captures the returned instruction one cycle later.
- Tags each instruction with its byte PC and presents it to decode through a valid/ready handshake.
- A 2-entry buffer makes decode back-pressure lossless; control redirects (branch/jump) flush in-flight work.

Parameters:
RESET_PC, 32'h00000000, byte address fetched first after reset; bits [1:0] ignored.
BUF_DEPTH, 2, output buffer entries; only 2 is supported.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
imem_addr  output  30  word address to the instruction ROM; ROM registers it, data returns next cycle
imem_inst  input  32  instruction word for the address presented in the previous cycle
redirect_valid  input  1  control-transfer request from execute
redirect_pc  input  32  target byte address; bits [1:0] ignored
out_valid  output  1  out_inst/out_pc hold a valid instruction
out_ready  input  1  decode accepts the head entry this cycle
out_inst  output  32  instruction at buffer head
out_pc  output  32  byte PC of out_inst, {word_addr, 2'b00}

Behaviour:
- State:
  - fetch_pc (30b): next word address to issue.
  - inflight (1b) and inflight_pc (30b): a word issued last cycle whose data is on imem_inst this cycle.
  - FIFO of 2 {inst, pc} entries, with count (0..2).
- Reset (rst low, asynchronous):
  - fetch_pc=RESET_PC[31:2], inflight=0, count=0.
  - out_valid=0, out_inst=0, out_pc=0.
  - imem_addr=RESET_PC[31:2] while in reset.
- pop = out_valid & out_ready. out_valid = (count!=0). out_inst/out_pc are the FIFO head; they are 0 when empty.
- Push: if inflight=1 and no redirect, {imem_inst, inflight_pc} enters the FIFO at the clock edge.
- Issue rule:
  - occ_next = count + inflight - pop.
  - issue = (occ_next < 2) | redirect_valid.
  - When issue=1: imem_addr=fetch_pc, fetch_pc<=fetch_pc+1, inflight<=1, inflight_pc<=fetch_pc.
  - Otherwise: imem_addr=fetch_pc (ROM re-reads harmlessly), inflight<=0.
- Throughput and latency:
  - Sustains 1 instruction/cycle with out_ready held high.
  - Latency is 2 cycles from issue to out_valid (1 cycle ROM, 1 cycle buffer).
  - First out_valid is the 2nd rising edge after reset release.
- Redirect (redirect_valid=1), highest priority:
  - imem_addr=redirect_pc[31:2] combinationally in the same cycle.
  - fetch_pc<=redirect_pc[31:2]+1, inflight<=1, inflight_pc<=redirect_pc[31:2].
  - count<=0 and the current imem_inst is discarded.
  - A pop coinciding with the redirect is a completed handshake; the entry is consumed and the remaining FIFO content is flushed.
  - Redirect-target instruction reaches out_valid 2 edges later.
  - Back-to-back redirects: the last one wins, with no stale output.
- Full/back-pressure:
  - With count=2, no new push is accepted, because the issue rule guarantees inflight=0 whenever count reaches 2.
  - Holding out_ready=0 never drops or duplicates an instruction; out_inst/out_pc are stable while out_valid=1 and out_ready=0.
- Wrap-around: fetch_pc+1 wraps 30'h3FFFFFFF -> 0; out_pc wraps to 32'h0.
- Reset mid-stream clears FIFO and inflight immediately; no instruction from before reset is ever emitted.
- All arithmetic is unsigned 30-bit; no overflow flags.

Test Plan:
- Reset, then out_ready=1, with a ROM image of 0:3c1d1000 1:37bd0100 2:3c028000 ... a:3c0c00ff (others 0):
  - out_valid rises on the 2nd edge after reset release.
  - Outputs are (pc 0, 3c1d1000), (pc 4, 37bd0100), (pc 8, 3c028000) on consecutive cycles, one per cycle.
- Stall: drop out_ready for 5 cycles after pc 4 appears.
  - pc 4 (37bd0100) is held stable and count reaches 2.
  - imem_addr stops advancing at word 3.
  - On release, the sequence continues pc 8, pc C, ... with no gap >1 cycle and no duplicates.
- Redirect: redirect_valid with redirect_pc=32'h00000028 while the FIFO holds 2 entries.
  - imem_addr=0xA in the same cycle and the FIFO is flushed.
  - 2 edges later, out_pc=0x28 and out_inst=3c0c00ff, followed by pc 0x2C and inst 0.
- Redirect coincident with pop, plus back-to-back redirects to 0x10 then 0x20: only pc 0x20 (ac4a0014) and its successors appear.
- Wrap: redirect_pc=32'hFFFFFFFC -> out_pc FFFFFFFC, then 00000000 (3c1d1000).
- Asynchronous reset asserted mid-stream between clock edges: out_valid=0 immediately; after release, fetch restarts at RESET_PC=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word addresses to a registered ROM, tags returned words with their
// byte PC and buffers them in a 2-entry FIFO for decode. Redirects flush all in-flight work.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [29:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_inst_o,
  output logic [31:0] out_pc_o
);

  localparam int unsigned CntW      = $clog2(BUF_DEPTH + 1);
  localparam logic [29:0] ResetWord = RESET_PC[31:2];

  logic [29:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [29:0]     inflight_pc_q, inflight_pc_d;
  logic [31:0]     head_inst_q, head_inst_d, tail_inst_q, tail_inst_d;
  logic [29:0]     head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  logic [CntW-1:0] count_q, count_d, occ_next, count_after_pop;
  logic            pop, push, issue;
  logic [29:0]     redirect_word;
  logic            unused_redirect_lsbs;

  assign redirect_word        = redirect_pc_i[31:2];
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  assign out_valid_o = (count_q != '0);
  assign out_inst_o  = out_valid_o ? head_inst_q : '0;
  assign out_pc_o    = out_valid_o ? {head_pc_q, 2'b00} : '0;

  always_comb begin
    pop      = out_valid_o & out_ready_i;
    push     = inflight_q & ~redirect_valid_i;
    // Occupancy once the word now on the ROM bus has landed; keeps room for the next issue.
    occ_next = count_q + CntW'(inflight_q) - CntW'(pop);
    issue    = (occ_next < CntW'(BUF_DEPTH)) | redirect_valid_i;

    if (!rst_ni) begin
      imem_addr_o = ResetWord;
    end else if (redirect_valid_i) begin
      imem_addr_o = redirect_word;
    end else begin
      imem_addr_o = fetch_pc_q;
    end
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid_i) begin
      fetch_pc_d    = redirect_word + 30'd1;
      inflight_d    = 1'b1;
      inflight_pc_d = redirect_word;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + 30'd1;
      inflight_d    = 1'b1;
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_comb begin
    head_inst_d     = head_inst_q;
    head_pc_d       = head_pc_q;
    tail_inst_d     = tail_inst_q;
    tail_pc_d       = tail_pc_q;
    count_after_pop = count_q - CntW'(pop);
    count_d         = count_q;
    if (redirect_valid_i) begin
      count_d = '0;
    end else begin
      if (pop) begin
        head_inst_d = tail_inst_q;
        head_pc_d   = tail_pc_q;
      end
      if (push) begin
        if (count_after_pop == '0) begin
          head_inst_d = imem_inst_i;
          head_pc_d   = inflight_pc_q;
        end else begin
          tail_inst_d = imem_inst_i;
          tail_pc_d   = inflight_pc_q;
        end
      end
      count_d = count_after_pop + CntW'(push);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= ResetWord;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      head_inst_q   <= '0;
      head_pc_q     <= '0;
      tail_inst_q   <= '0;
      tail_pc_q     <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_inst_q   <= head_inst_d;
      head_pc_q     <= head_pc_d;
      tail_inst_q   <= tail_inst_d;
      tail_pc_q     <= tail_pc_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table for start-up/stall/redirect, hand sequences for
// coincident and back-to-back redirects, wrap-around and mid-cycle reset; scoreboard on handshakes.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] imem_addr;
  logic [31:0] imem_inst = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [29:0] exp_addr;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  vec_t vecs [18];
  exp_t sb_q [$];

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .imem_addr_o     (imem_addr),
    .imem_inst_i     (imem_inst),
    .redirect_valid_i(redirect_valid),
    .redirect_pc_i   (redirect_pc),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_inst_o      (out_inst),
    .out_pc_o        (out_pc)
  );

  function automatic logic [31:0] rom_f(input logic [29:0] a);
    case (a)
      30'h0:   return 32'h3c1d1000;
      30'h1:   return 32'h37bd0100;
      30'h2:   return 32'h3c028000;
      30'h3:   return 32'h34420001;
      30'h4:   return 32'h00400821;
      30'h5:   return 32'h8c220004;
      30'h6:   return 32'h24630001;
      30'h7:   return 32'h1460fffd;
      30'h8:   return 32'hac4a0014;
      30'h9:   return 32'h01094020;
      30'hA:   return 32'h3c0c00ff;
      default: return 32'h0;
    endcase
  endfunction

  // Registered ROM: data for the address seen at an edge appears after that edge.
  always @(posedge clk) imem_inst <= rom_f(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic sb_restart(input logic [31:0] pc);
    logic [29:0] w;
    exp_t        e;
    sb_q.delete();
    w = pc[31:2];
    for (int i = 0; i < 16; i++) begin
      e.pc   = {w, 2'b00};
      e.inst = rom_f(w);
      sb_q.push_back(e);
      w = w + 30'd1;
    end
  endtask

  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got pc %08h, expected no output", out_pc);
      end else begin
        e = sb_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_inst", out_inst, e.inst);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h00000000, 30'h0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h00000000, 30'h1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h00, 32'h3c1d1000, 30'h2};
    vecs[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h37bd0100, 30'h3};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h37bd0100, 30'h3};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h37bd0100, 30'h3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h37bd0100, 30'h3};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h04, 32'h37bd0100, 30'h3};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h04, 32'h37bd0100, 30'h3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h08, 32'h3c028000, 30'h4};
    vecs[10] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h0C, 32'h34420001, 30'h5};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h10, 32'h00400821, 30'h6};
    vecs[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 32'h8c220004, 30'h7};
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 32'h8c220004, 30'h7};
    vecs[14] = '{1'b0, 1'b1, 32'h28, 1'b1, 32'h14, 32'h8c220004, 30'hA};
    vecs[15] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h00000000, 30'hB};
    vecs[16] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h28, 32'h3c0c00ff, 30'hC};
    vecs[17] = '{1'b1, 1'b0, 32'h0,  1'b1, 32'h2C, 32'h00000000, 30'hD};

    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_inst", out_inst, 32'h0);
    check("rst_addr", {2'b00, imem_addr}, 32'h0);
    rst_n = 1'b1;
    sb_restart(32'h0);

    for (int i = 0; i < 18; i++) begin
      out_ready      = vecs[i].rdy;
      redirect_valid = vecs[i].rv;
      redirect_pc    = vecs[i].rpc;
      sample();
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_v});
      check($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_addr", i), {2'b00, imem_addr}, {2'b00, vecs[i].exp_addr});
      if (vecs[i].rv) sb_restart(vecs[i].rpc);
      advance();
    end

    // Redirect coinciding with a pop, then a second redirect on the next cycle.
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    sample();
    check("coinc_valid", {31'b0, out_valid}, 32'h1);
    check("coinc_pc", out_pc, 32'h30);
    check("coinc_addr", {2'b00, imem_addr}, 32'h4);
    sb_restart(32'h10);
    advance();
    redirect_pc = 32'h20;
    sample();
    check("b2b_valid", {31'b0, out_valid}, 32'h0);
    check("b2b_addr", {2'b00, imem_addr}, 32'h8);
    sb_restart(32'h20);
    advance();
    redirect_valid = 1'b0;
    sample();
    check("b2b_gap_valid", {31'b0, out_valid}, 32'h0);
    check("b2b_gap_addr", {2'b00, imem_addr}, 32'h9);
    advance();
    sample();
    check("b2b_first_valid", {31'b0, out_valid}, 32'h1);
    check("b2b_first_pc", out_pc, 32'h20);
    check("b2b_first_inst", out_inst, 32'hac4a0014);
    advance();
    repeat (3) begin
      sample();
      advance();
    end

    // Wrap-around of the word address.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFFFFFC;
    sample();
    check("wrap_addr", {2'b00, imem_addr}, 32'h3FFFFFFF);
    sb_restart(32'hFFFFFFFC);
    advance();
    redirect_valid = 1'b0;
    sample();
    check("wrap_gap_valid", {31'b0, out_valid}, 32'h0);
    check("wrap_next_addr", {2'b00, imem_addr}, 32'h0);
    advance();
    sample();
    check("wrap_top_pc", out_pc, 32'hFFFFFFFC);
    check("wrap_top_inst", out_inst, 32'h0);
    advance();
    sample();
    check("wrap_zero_pc", out_pc, 32'h0);
    check("wrap_zero_inst", out_inst, 32'h3c1d1000);
    advance();
    repeat (2) begin
      sample();
      advance();
    end

    // Asynchronous reset between clock edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'h0);
    check("arst_pc", out_pc, 32'h0);
    check("arst_inst", out_inst, 32'h0);
    check("arst_addr", {2'b00, imem_addr}, 32'h0);
    sb_q.delete();
    advance();
    check("arst_hold_valid", {31'b0, out_valid}, 32'h0);
    advance();
    rst_n = 1'b1;
    sb_restart(32'h0);
    sample();
    check("rel_c0_valid", {31'b0, out_valid}, 32'h0);
    advance();
    sample();
    check("rel_c1_valid", {31'b0, out_valid}, 32'h0);
    advance();
    sample();
    check("rel_c2_valid", {31'b0, out_valid}, 32'h1);
    check("rel_c2_pc", out_pc, 32'h0);
    check("rel_c2_inst", out_inst, 32'h3c1d1000);
    advance();
    repeat (3) begin
      sample();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
